// File: rtl/dma_dev_arbiter.sv
// Round-robin arbiter sharing the single device-side port of dma_controller among
// NUM_DEV devices; a grant is locked for one transfer, with a sticky hold-time watchdog.
module dma_dev_arbiter #(
    parameter int NUM_DEV     = 4,
    parameter int ADD_LEN     = 5,
    parameter int DATA_LEN    = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_DEV-1:0]                dev_rqst,
    input  logic [NUM_DEV-1:0]                dev_rd_wr,
    input  logic [NUM_DEV*ADD_LEN-1:0]        dev_start_addr,
    input  logic [NUM_DEV*(FIFO_DEPTH+1)-1:0] dev_num_words,
    input  logic [NUM_DEV-1:0]                dev_ack_in,
    input  logic [NUM_DEV*DATA_LEN-1:0]       dev_data_in,
    output logic [NUM_DEV-1:0]                dev_dma_ack,
    output logic [NUM_DEV-1:0]                dev_end_flag,
    output logic [DATA_LEN-1:0]               dev_data_out,
    output logic [NUM_DEV-1:0]                grant,
    output logic                              rqst,
    output logic                              rd_wr,
    output logic [ADD_LEN-1:0]                start_addr,
    output logic [FIFO_DEPTH:0]               num_words,
    output logic                              dev_ack,
    output logic [DATA_LEN-1:0]               dev_out,
    input  logic                              dma_ack,
    input  logic [DATA_LEN-1:0]               dma_dev_in,
    input  logic                              end_flag,
    output logic                              err,
    output logic [2:0]                        err_dev,
    output logic [1:0]                        fsm_state
);

    localparam int OW    = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int NW    = FIFO_DEPTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [OW-1:0]      owner, owner_nxt;
    logic [OW-1:0]      rr_ptr, rr_nxt;
    logic [NUM_DEV-1:0] grant_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt;
    logic               err_nxt;
    logic [2:0]         err_dev_nxt;

    logic               pick_valid;
    logic [OW-1:0]      pick_idx;
    logic [OW-1:0]      owner_inc;
    logic               timeout_hit;

    // First requester at or after rr_ptr, wrapping modulo NUM_DEV.
    always_comb begin : pick_blk
        int k;
        k          = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            k = (int'(rr_ptr) + i) % NUM_DEV;
            if (!pick_valid && dev_rqst[k]) begin
                pick_valid = 1'b1;
                pick_idx   = OW'(k);
            end
        end
    end

    assign owner_inc   = (owner == OW'(NUM_DEV - 1)) ? '0 : owner + 1'b1;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (hold_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            grant    <= '0;
            hold_cnt <= '0;
            err      <= 1'b0;
            err_dev  <= 3'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            grant    <= grant_nxt;
            hold_cnt <= hold_nxt;
            err      <= err_nxt;
            err_dev  <= err_dev_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        grant_nxt   = grant;
        hold_nxt    = hold_cnt;
        err_nxt     = err;
        err_dev_nxt = err_dev;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_nxt = pick_idx;
                    grant_nxt = NUM_DEV'(1) << pick_idx;
                    hold_nxt  = '0;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                // A completion in the same cycle as the timeout is a clean release.
                if (end_flag) begin
                    rr_nxt    = owner_inc;
                    grant_nxt = '0;
                    state_nxt = RELEASE;
                end else if (timeout_hit) begin
                    err_nxt     = 1'b1;
                    err_dev_nxt = 3'(owner);
                    rr_nxt      = owner_inc;
                    grant_nxt   = '0;
                    state_nxt   = RELEASE;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Controller-side muxes follow the owner only while locked; otherwise all zero.
    always_comb begin
        rqst       = 1'b0;
        rd_wr      = 1'b0;
        start_addr = '0;
        num_words  = '0;
        dev_ack    = 1'b0;
        dev_out    = '0;
        if (state == LOCKED) begin
            rqst       = dev_rqst[owner];
            rd_wr      = dev_rd_wr[owner];
            start_addr = dev_start_addr[owner*ADD_LEN +: ADD_LEN];
            num_words  = dev_num_words[owner*NW +: NW];
            dev_ack    = dev_ack_in[owner];
            dev_out    = dev_data_in[owner*DATA_LEN +: DATA_LEN];
        end
    end

    assign dev_dma_ack  = grant & {NUM_DEV{dma_ack}};
    assign dev_end_flag = grant & {NUM_DEV{end_flag}};
    assign dev_data_out = dma_dev_in;
    assign fsm_state    = state;

endmodule

// File: tb/tb_dma_dev_arbiter.sv
// Randomized bench for dma_dev_arbiter: a transaction-level model of owner, pointer and
// watchdog predicts every output each cycle.
module tb_dma_dev_arbiter;

    localparam int N   = 4;
    localparam int AL  = 5;
    localparam int DL  = 8;
    localparam int FD  = 4;
    localparam int NW  = FD + 1;
    localparam int TO  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     dev_rqst, dev_rd_wr, dev_ack_in;
    logic [N*AL-1:0]  dev_start_addr;
    logic [N*NW-1:0]  dev_num_words;
    logic [N*DL-1:0]  dev_data_in;
    logic [N-1:0]     dev_dma_ack, dev_end_flag, grant;
    logic [DL-1:0]    dev_data_out, dev_out, dma_dev_in;
    logic             rqst, rd_wr, dev_ack, dma_ack, end_flag, err;
    logic [AL-1:0]    start_addr;
    logic [NW-1:0]    num_words;
    logic [2:0]       err_dev;
    logic [1:0]       fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard word: {err, err_dev[2:0], grant[3:0]}
    logic [7:0] exp_q[$];

    // Reference model state
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_rel;
    bit m_err;
    int m_err_dev;

    dma_dev_arbiter #(
        .NUM_DEV(N), .ADD_LEN(AL), .DATA_LEN(DL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr), .dev_start_addr(dev_start_addr),
        .dev_num_words(dev_num_words), .dev_ack_in(dev_ack_in), .dev_data_in(dev_data_in),
        .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag), .dev_data_out(dev_data_out),
        .grant(grant), .rqst(rqst), .rd_wr(rd_wr), .start_addr(start_addr),
        .num_words(num_words), .dev_ack(dev_ack), .dev_out(dev_out),
        .dma_ack(dma_ack), .dma_dev_in(dma_dev_in), .end_flag(end_flag),
        .err(err), .err_dev(err_dev), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference: who owns the port after this edge.
    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_rel = 0; m_err = 0; m_err_dev = 0;
        end else if (m_owner >= 0) begin
            if (end_flag) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_rel = 1;
            end else if (m_held == TO - 1) begin
                m_err = 1; m_err_dev = m_owner;
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_rel = 1;
            end else begin
                m_held++;
            end
        end else if (m_rel) begin
            m_rel = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && dev_rqst[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_held  = 0;
                end
            end
        end
        exp_q.push_back({m_err, 3'(m_err_dev), (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0});
    endtask

    task automatic check_outputs();
        logic [7:0] e;
        bit         own;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e   = exp_q.pop_front();
        own = (m_owner >= 0);
        check("grant", 32'(grant), 32'(e[3:0]));
        check("err", 32'(err), 32'(e[7]));
        check("err_dev", 32'(err_dev), 32'(e[6:4]));
        check("rqst", 32'(rqst), own ? 32'(dev_rqst[m_owner]) : 32'd0);
        check("rd_wr", 32'(rd_wr), own ? 32'(dev_rd_wr[m_owner]) : 32'd0);
        check("start_addr", 32'(start_addr), own ? 32'(dev_start_addr[m_owner*AL +: AL]) : 32'd0);
        check("num_words", 32'(num_words), own ? 32'(dev_num_words[m_owner*NW +: NW]) : 32'd0);
        check("dev_ack", 32'(dev_ack), own ? 32'(dev_ack_in[m_owner]) : 32'd0);
        check("dev_out", 32'(dev_out), own ? 32'(dev_data_in[m_owner*DL +: DL]) : 32'd0);
        check("dev_dma_ack", 32'(dev_dma_ack), (own && dma_ack) ? 32'(1 << m_owner) : 32'd0);
        check("dev_end_flag", 32'(dev_end_flag), (own && end_flag) ? 32'(1 << m_owner) : 32'd0);
        check("dev_data_out", 32'(dev_data_out), 32'(dma_dev_in));
    endtask

    // Drive random inputs at the falling edge, check, then advance the model at the rising edge.
    task automatic run_cycles(input int n, input int rq_pct, input int end_pct, input int rst_pm);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 999) < rst_pm);
            for (int d = 0; d < N; d++) dev_rqst[d] = ($urandom_range(0, 99) < rq_pct);
            dev_rd_wr      = N'($urandom);
            dev_ack_in     = N'($urandom);
            dev_start_addr = (N*AL)'($urandom);
            dev_num_words  = (N*NW)'($urandom);
            dev_data_in    = (N*DL)'($urandom);
            dma_ack        = 1'($urandom);
            dma_dev_in     = DL'($urandom);
            end_flag       = ($urandom_range(0, 99) < end_pct);
            #1;
            check_outputs();
            @(posedge clk);
            model_step();
        end
    endtask

    initial begin
        reset = 1'b1;
        dev_rqst = '0; dev_rd_wr = '0; dev_ack_in = '0; dev_start_addr = '0;
        dev_num_words = '0; dev_data_in = '0; dma_ack = 1'b0; dma_dev_in = '0; end_flag = 1'b0;
        @(posedge clk);
        model_step();
        run_cycles(1, 0, 0, 1000);
        run_cycles(400, 40, 30, 0);
        run_cycles(600, 60, 0, 0);
        run_cycles(300, 100, 60, 0);
        run_cycles(800, 50, 10, 5);
        run_cycles(300, 30, 3, 20);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

endmodule
